// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and hazard-stall control for the EX stage, with a one-entry MUL/DIV scoreboard.
// Optional stall performance counter enabled by defining FWD_PERF_CNT_EN.
module fwd_hazard_ctrl #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned NREG    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SRC*5-1:0]   rs_ex,
    input  logic [NUM_SRC-1:0]     rs_used_ex,
    input  logic [4:0]             rd_mem,
    input  logic                   reg_write_mem,
    input  logic                   is_load_mem,
    input  logic [4:0]             rd_wb,
    input  logic                   reg_write_wb,
    input  logic                   md_issue,
    input  logic [4:0]             md_rd,
    input  logic                   md_wb,
    input  logic                   md_kill,
    output logic [NUM_SRC*2-1:0]   fwd_sel,
    output logic                   stall_ex,
    output logic                   md_busy,
    output logic                   md_err,
    output logic [31:0]            stall_cycles
);

    logic [NREG-1:0] pending_q, pending_d;
    logic [4:0]      md_rd_q, md_rd_d;
    logic            md_busy_q, md_busy_d;
    logic            md_err_q, md_err_d;

    // Scoreboard widened to the full 5-bit index space so any index can be looked up safely.
    logic [31:0]     pend_full;
    logic [31:0]     pend_next;
    logic [4:0]      rs;
    logic            mem_hit;
    logic            wb_hit;
    logic            md_done;

    always_comb begin
        pend_full             = '0;
        pend_full[NREG-1:0]   = pending_q;
        fwd_sel               = '0;
        stall_ex              = 1'b0;
        rs                    = '0;
        mem_hit               = 1'b0;
        wb_hit                = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs      = rs_ex[5*i +: 5];
            mem_hit = reg_write_mem && (rd_mem == rs) && (rd_mem != 5'd0);
            wb_hit  = reg_write_wb && (rd_wb == rs) && (rd_wb != 5'd0);
            if (rs_used_ex[i]) begin
                if (((rs != 5'd0) && pend_full[rs]) || (mem_hit && is_load_mem)) begin
                    stall_ex = 1'b1;
                end else if (mem_hit) begin
                    fwd_sel[2*i +: 2] = 2'b01;
                end else if (wb_hit) begin
                    fwd_sel[2*i +: 2] = 2'b10;
                end
            end
        end
    end

    always_comb begin
        md_done   = md_wb || md_kill;
        pend_next = pend_full;
        md_busy_d = md_busy_q;
        md_rd_d   = md_rd_q;
        md_err_d  = md_err_q;
        if (md_done) begin
            if (md_busy_q) begin
                pend_next[md_rd_q] = 1'b0;
                md_busy_d          = 1'b0;
            end else begin
                md_err_d = 1'b1;
            end
        end
        // Issue applied after retire so a same-register reissue stays pending.
        if (md_issue) begin
            if (!md_busy_q || md_done) begin
                md_busy_d = 1'b1;
                md_rd_d   = md_rd;
                if (md_rd != 5'd0) begin
                    pend_next[md_rd] = 1'b1;
                end
            end else begin
                md_err_d = 1'b1;
            end
        end
        pend_next[0] = 1'b0;
        pending_d    = pend_next[NREG-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            md_rd_q   <= '0;
            md_busy_q <= 1'b0;
            md_err_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            md_rd_q   <= md_rd_d;
            md_busy_q <= md_busy_d;
            md_err_q  <= md_err_d;
        end
    end

    assign md_busy = md_busy_q;
    assign md_err  = md_err_q;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall_ex};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed spot checks plus randomized run against a model.
module tb_fwd_hazard_ctrl;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*5-1:0] rs_ex;
    logic [N-1:0]   rs_used_ex;
    logic [4:0]     rd_mem, rd_wb, md_rd;
    logic           reg_write_mem, is_load_mem, reg_write_wb;
    logic           md_issue, md_wb, md_kill;
    logic [N*2-1:0] fwd_sel;
    logic           stall_ex, md_busy, md_err;
    logic [31:0]    stall_cycles;

    int total = 0;
    int bad   = 0;

    // Reference state: set of registers awaiting a MUL/DIV result, plus the op in flight.
    bit [31:0] m_pend;
    bit        m_busy;
    bit [4:0]  m_rd;
    bit        m_err;
    bit [31:0] m_cnt;

    logic [N*2-1:0] e_sel;
    logic           e_stall;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.NUM_SRC(N), .NREG(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .rs_ex        (rs_ex),
        .rs_used_ex   (rs_used_ex),
        .rd_mem       (rd_mem),
        .reg_write_mem(reg_write_mem),
        .is_load_mem  (is_load_mem),
        .rd_wb        (rd_wb),
        .reg_write_wb (reg_write_wb),
        .md_issue     (md_issue),
        .md_rd        (md_rd),
        .md_wb        (md_wb),
        .md_kill      (md_kill),
        .fwd_sel      (fwd_sel),
        .stall_ex     (stall_ex),
        .md_busy      (md_busy),
        .md_err       (md_err),
        .stall_cycles (stall_cycles)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_out();
        logic [4:0] r;
        e_sel   = '0;
        e_stall = 1'b0;
        for (int i = 0; i < N; i++) begin
            r = rs_ex[5*i +: 5];
            if (rs_used_ex[i]) begin
                if (r != 0 && m_pend[r]) e_stall = 1'b1;
                else if (reg_write_mem && rd_mem == r && r != 0) begin
                    if (is_load_mem) e_stall = 1'b1;
                    else e_sel[2*i +: 2] = 2'b01;
                end else if (reg_write_wb && rd_wb == r && r != 0) e_sel[2*i +: 2] = 2'b10;
            end
        end
    endfunction

    // Sample at the falling edge and compare everything against the model.
    task automatic probe();
        @(negedge clk);
        model_out();
        check("fwd_sel", 32'(fwd_sel), 32'(e_sel));
        check("stall_ex", 32'(stall_ex), 32'(e_stall));
        check("md_busy", 32'(md_busy), 32'(m_busy));
        check("md_err", 32'(md_err), 32'(m_err));
`ifdef FWD_PERF_CNT_EN
        check("stall_cycles", stall_cycles, m_cnt);
`else
        check("stall_cycles", stall_cycles, 32'd0);
`endif
    endtask

    // Advance one edge and update the model in event order: retire first, then issue.
    task automatic adv();
        model_out();
        @(posedge clk);
        if (rst) begin
            m_pend = '0; m_busy = 0; m_rd = '0; m_err = 0; m_cnt = '0;
        end else begin
            if (e_stall) m_cnt = m_cnt + 1;
            if (md_wb || md_kill) begin
                if (m_busy) begin
                    m_pend[m_rd] = 1'b0;
                    m_busy       = 1'b0;
                end else m_err = 1'b1;
            end
            if (md_issue) begin
                if (!m_busy) begin
                    m_busy = 1'b1;
                    m_rd   = md_rd;
                    if (md_rd != 0) m_pend[md_rd] = 1'b1;
                end else m_err = 1'b1;
            end
        end
        #1;
    endtask

    task automatic step();
        probe();
        adv();
    endtask

    task automatic idle_inputs();
        rs_ex = '0; rs_used_ex = '0; rd_mem = '0; reg_write_mem = 0; is_load_mem = 0;
        rd_wb = '0; reg_write_wb = 0; md_issue = 0; md_rd = '0; md_wb = 0; md_kill = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        m_pend = '0; m_busy = 0; m_rd = '0; m_err = 0; m_cnt = '0;
        @(posedge clk);
        #1;
        probe();
        check("reset_busy", 32'(md_busy), 32'd0);
        check("reset_cnt", stall_cycles, 32'd0);
        adv();
        rst = 1'b0;

        // MEM beats WB on both operands.
        rs_ex = {5'd5, 5'd5}; rs_used_ex = 2'b11;
        reg_write_mem = 1; rd_mem = 5'd5; reg_write_wb = 1; rd_wb = 5'd5;
        probe();
        check("mem_prio_sel", 32'(fwd_sel), 32'h5);
        check("mem_prio_stall", 32'(stall_ex), 32'd0);
        adv();

        // Load-use stall, no WB fallback.
        idle_inputs();
        rs_ex = 10'd7; rs_used_ex = 2'b01;
        rd_mem = 5'd7; reg_write_mem = 1; is_load_mem = 1; rd_wb = 5'd7; reg_write_wb = 1;
        probe();
        check("load_use_sel", 32'(fwd_sel), 32'd0);
        check("load_use_stall", 32'(stall_ex), 32'd1);
        adv();
        idle_inputs();
        rs_ex = '0; rs_used_ex = 2'b11; rd_mem = '0; reg_write_mem = 1;
        probe();
        check("x0_sel", 32'(fwd_sel), 32'd0);
        adv();

        // MUL/DIV to x9, consumer stalls through the wb cycle.
        idle_inputs();
        md_issue = 1; md_rd = 5'd9;
        step();
        md_issue = 0;
        rs_ex = 10'd9; rs_used_ex = 2'b01;
        probe();
        check("md_stall0", 32'(stall_ex), 32'd1);
        check("md_busy1", 32'(md_busy), 32'd1);
        adv();
        step();
        md_wb = 1;
        probe();
        check("md_wb_stall", 32'(stall_ex), 32'd1);
        adv();
        md_wb = 0; rd_wb = 5'd9; reg_write_wb = 1;
        probe();
        check("md_release", 32'(stall_ex), 32'd0);
        check("md_release_sel", 32'(fwd_sel), 32'd2);
        check("md_busy0", 32'(md_busy), 32'd0);
        adv();

        // Issue while busy, then kill+issue on the same edge.
        idle_inputs();
        md_issue = 1; md_rd = 5'd8;
        step();
        md_rd = 5'd3;
        step();
        md_issue = 0;
        rs_ex = 10'd3; rs_used_ex = 2'b01;
        probe();
        check("busy_issue_err", 32'(md_err), 32'd1);
        check("busy_issue_nopend", 32'(stall_ex), 32'd0);
        adv();
        md_kill = 1; md_issue = 1; md_rd = 5'd4;
        step();
        md_kill = 0; md_issue = 0;
        rs_ex = {5'd4, 5'd8}; rs_used_ex = 2'b01;
        probe();
        check("kill_old_clear", 32'(stall_ex), 32'd0);
        adv();
        rs_used_ex = 2'b10;
        probe();
        check("kill_new_pend", 32'(stall_ex), 32'd1);
        adv();

        // Ten stall cycles, then reset mid-stall.
        idle_inputs();
        rst = 1; step(); rst = 0;
        md_issue = 1; md_rd = 5'd6;
        step();
        md_issue = 0; rs_ex = 10'd6; rs_used_ex = 2'b01;
        repeat (10) step();
        probe();
`ifdef FWD_PERF_CNT_EN
        check("perf_10", stall_cycles, 32'd10);
`else
        check("perf_off", stall_cycles, 32'd0);
`endif
        adv();
        rst = 1;
        step();
        rst = 0;
        probe();
        check("rst_mid_stall", 32'(stall_ex), 32'd0);
        check("rst_mid_cnt", stall_cycles, 32'd0);
        adv();

        // Randomized run over a small register window to provoke frequent matches.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) rs_ex[5*i +: 5] = 5'($urandom_range(0, 7));
            rs_used_ex    = N'($urandom);
            rd_mem        = 5'($urandom_range(0, 7));
            reg_write_mem = ($urandom_range(0, 2) != 0);
            is_load_mem   = ($urandom_range(0, 3) == 0);
            rd_wb         = 5'($urandom_range(0, 7));
            reg_write_wb  = ($urandom_range(0, 2) != 0);
            md_issue      = ($urandom_range(0, 5) == 0);
            md_rd         = 5'($urandom_range(0, 7));
            md_wb         = ($urandom_range(0, 7) == 0);
            md_kill       = ($urandom_range(0, 15) == 0);
            rst           = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 2: number of EX-stage source operands served (1..4).
REQ-002 Parameter NREG, default 32: architectural register count; register index width is 5 bits.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rs_ex  input  NUM_SRC*5  EX-stage source indices; operand i occupies bits [5i+4:5i].
REQ-006 rs_used_ex  input  NUM_SRC  operand i is actually read by the EX instruction.
REQ-007 rd_mem / reg_write_mem / is_load_mem  input  5/1/1  EX/MEM destination, write enable, load flag.
REQ-008 rd_wb / reg_write_wb  input  5/1  MEM/WB destination and write enable.
REQ-009 md_issue / md_rd  input  1/5  one-cycle pulse: multi-cycle MUL/DIV op leaves EX with destination md_rd.
REQ-010 md_wb  input  1  one-cycle pulse: the outstanding MUL/DIV result is written back this cycle.
REQ-011 md_kill  input  1  one-cycle pulse: the outstanding MUL/DIV op is aborted (pipeline flush).
REQ-012 fwd_sel  output  NUM_SRC*2  per-operand select: 00 regfile, 01 MEM, 10 WB; 11 never driven.
REQ-013 stall_ex  output  1  EX instruction must hold this cycle.
REQ-014 md_busy / md_err  output  1/1  MUL/DIV op outstanding; sticky protocol-error flag.
REQ-015 stall_cycles  output  32  stall performance counter.

Function
REQ-016 fwd_sel and stall_ex are combinational from the current inputs and registered state (zero-cycle latency).
REQ-017 Operand i selects 01 when rs_used_ex[i], reg_write_mem, rd_mem==rs_i, rd_mem!=0 and is_load_mem==0.
REQ-018 Otherwise operand i selects 10 when rs_used_ex[i], reg_write_wb, rd_wb==rs_i and rd_wb!=0; MEM match takes priority over WB.
REQ-019 Load-use: a used operand matching rd_mem (nonzero) while reg_write_mem and is_load_mem are high asserts stall_ex; that operand's fwd_sel is 00, not WB.
REQ-020 Scoreboard: registered pending vector of NREG bits plus 5-bit md_rd_q; bit 0 is never set.
REQ-021 md_issue while md_busy==0 and md_rd!=0 sets pending[md_rd], captures md_rd_q and sets md_busy on the next edge.
REQ-022 md_issue with md_rd==0 sets md_busy but no pending bit.
REQ-023 md_wb or md_kill while md_busy clears pending[md_rd_q] and md_busy on the next edge.
REQ-024 md_issue coinciding with md_wb/md_kill: clear old entry and accept new issue in the same edge; on the same register, set wins.
REQ-025 md_issue while md_busy (without simultaneous wb/kill) is ignored and sets md_err; md_wb or md_kill while idle is ignored and sets md_err.
REQ-026 Any used nonzero operand whose pending bit is set asserts stall_ex and forces its fwd_sel to 00.
REQ-027 In the md_wb cycle, the pending register is still set (state is registered) and stall_ex remains high; release occurs in the following cycle via normal WB forwarding or the regfile.
REQ-028 Unused operands (rs_used_ex[i]==0) always give fwd_sel 00 and never cause a stall.

Reset
REQ-029 On rst high at a clock edge: pending all zero, md_rd_q=0, md_busy=0, md_err=0, stall_cycles=0.
REQ-030 rst takes priority over simultaneous md_issue/md_wb/md_kill; an in-flight op is forgotten.
REQ-031 The combinational outputs follow their rules during reset, using the zeroed state.

Configuration
REQ-032 Macro FWD_PERF_CNT_EN: when defined, stall_cycles increments by 1 on every edge with stall_ex high and rst low, wrapping from 0xFFFFFFFF to 0.
REQ-033 When FWD_PERF_CNT_EN is undefined, stall_cycles is constant 0 and no counter flops are built; all other behaviour is identical.

Verification
REQ-034 rs_ex={x5,x5}, both used, reg_write_mem=1, rd_mem=5, reg_write_wb=1, rd_wb=5 -> fwd_sel=0101, stall_ex=0.
REQ-035 rs1=x7 used, rd_mem=7, is_load_mem=1, rd_wb=7, reg_write_wb=1 -> fwd_sel[1:0]=00, stall_ex=1; rd_mem=0 and reg_write_mem=1 -> fwd_sel 00.
REQ-036 md_issue md_rd=9; next cycle rs1=x9 used -> stall_ex=1 until the cycle after the md_wb pulse, then 0; md_busy 1->0.
REQ-037 md_issue rd=3 while busy -> md_err=1, pending[3] stays 0; md_kill on the same edge as md_issue rd=4 -> only pending[4] set afterwards.
REQ-038 With FWD_PERF_CNT_EN defined: 10 consecutive stall cycles -> stall_cycles=10; rst mid-stall -> 0 and pending cleared next cycle.
